// File: rtl/alu_iterative_pkg.sv
// Shared ALU control codes, FSM state encoding and default sizing for the iterative ALU.
package alu_iterative_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_CNT_W = 6;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_iterative_if.sv
// Operand/control request and result bundle between the ID/EX stage and the ALU.
interface alu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             done;
    logic             busy;

    modport master (
        output valid, alu_ctrl, data1, data2,
        input  data, zero, done, busy
    );

    modport slave (
        input  valid, alu_ctrl, data1, data2,
        output data, zero, done, busy
    );
endinterface

// File: rtl/alu_iterative_mul_shift_add.sv
// Radix-2 shift-add multiplier core; one partial product per cycle while run is high.
module mul_shift_add #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next,
    output logic             last
);
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    // acc_next is what acc becomes on this edge, so the top can capture the final product directly
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign last     = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (run) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a multi-cycle multiply that stalls via busy.
module alu_iterative
    import alu_iterative_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input logic            clk,
    input logic            rst,
    alu_iterative_if.slave bus
);
    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_run;
    logic             mul_finish;
    logic             single_load;
    logic             busy;
    logic             mul_last;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             done_q;

    assign accept = bus.valid && (state == ST_IDLE);
    assign is_mul = (bus.alu_ctrl == ALU_MUL);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_last)         state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == ST_MUL);
        mul_run     = (state == ST_MUL);
        mul_start   = accept && is_mul;
        single_load = accept && !is_mul;
        mul_finish  = (state == ST_MUL) && mul_last;
    end

    // True signed compare for SLT; the sign of A-B is wrong when the subtraction overflows
    always_comb begin
        single_res = '0;
        case (bus.alu_ctrl)
            ALU_AND: single_res = bus.data1 & bus.data2;
            ALU_OR:  single_res = bus.data1 | bus.data2;
            ALU_ADD: single_res = bus.data1 + bus.data2;
            ALU_SUB: single_res = bus.data1 - bus.data2;
            ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
            default: single_res = '0;
        endcase
    end

    mul_shift_add #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .run      (mul_run),
        .a        (bus.data1),
        .b        (bus.data2),
        .acc_next (mul_acc_next),
        .last     (mul_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            zero_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (single_load) begin
                data_q <= single_res;
                zero_q <= (single_res == '0);
                done_q <= 1'b1;
            end else if (mul_finish) begin
                data_q <= mul_acc_next;
                zero_q <= (mul_acc_next == '0);
                done_q <= 1'b1;
            end
        end
    end

    assign bus.data = data_q;
    assign bus.zero = zero_q;
    assign bus.done = done_q;
    assign bus.busy = busy;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative with hand-computed expected results.
module tb_alu_iterative;
    import alu_iterative_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_iterative_if #(.WIDTH(32)) bus ();

    alu_iterative dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid    = 1'b1;
        bus.alu_ctrl = op;
        bus.data1    = a;
        bus.data2    = b;
        tick();
        bus.valid    = 1'b0;
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expd);
        issue(op, a, b);
        chk({tag, "_data"}, bus.data, expd);
        chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, (expd == 32'd0)});
        chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        tick();
        chk({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_hold"}, bus.data, expd);
    endtask

    // Called just after the accept edge; edges stays -1 if done never arrives within the bound
    task automatic wait_done(output int edges, output int busy_cnt, output int changes);
        logic [31:0] d0;
        d0       = bus.data;
        edges    = -1;
        busy_cnt = 0;
        changes  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busy_cnt++;
            tick();
            if (bus.data !== d0 && !bus.done) changes++;
            if (bus.done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expd, input logic poke_add);
        int edges;
        int busy_cnt;
        int changes;
        issue(ALU_MUL, a, b);
        chk({tag, "_busy_start"}, {31'b0, bus.busy}, 32'd1);
        chk({tag, "_done_start"}, {31'b0, bus.done}, 32'd0);
        if (poke_add) begin
            bus.valid    = 1'b1;
            bus.alu_ctrl = ALU_ADD;
            bus.data1    = 32'd1;
            bus.data2    = 32'd1;
        end
        wait_done(edges, busy_cnt, changes);
        bus.valid = 1'b0;
        chk({tag, "_latency"}, edges, 32'd32);
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd32);
        chk({tag, "_data_stable"}, changes, 32'd0);
        chk({tag, "_data"}, bus.data, expd);
        chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, (expd == 32'd0)});
        chk({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.alu_ctrl = 3'b000;
        bus.data1    = '0;
        bus.data2    = '0;
        tick();
        tick();
        chk("rst_data", bus.data, 32'd0);
        chk("rst_zero", {31'b0, bus.zero}, 32'd1);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        tick();

        single("add_5_7", ALU_ADD, 32'd5, 32'd7, 32'd12);
        single("sub_eq", ALU_SUB, 32'h1234, 32'h1234, 32'd0);
        single("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        single("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        single("or", ALU_OR, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001);
        single("slt_m1_1", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single("slt_max_min", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        single("slt_min_max", ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        single("unused_011", 3'b011, 32'd9, 32'd9, 32'd0);
        single("add_nz", ALU_ADD, 32'd40, 32'd2, 32'd42);
        single("unused_101", 3'b101, 32'd9, 32'd9, 32'd0);

        // valid low: no done, result held
        bus.alu_ctrl = ALU_ADD;
        bus.data1    = 32'd100;
        bus.data2    = 32'd100;
        tick();
        chk("idle_done", {31'b0, bus.done}, 32'd0);
        chk("idle_hold", bus.data, 32'd0);

        single("pre_mul", ALU_ADD, 32'd10, 32'd1, 32'd11);
        mul("mul_ffff_2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        tick();
        chk("mul_after_done", {31'b0, bus.done}, 32'd0);
        chk("mul_after_data", bus.data, 32'hFFFF_FFFE);
        mul("mul_6_7", 32'd6, 32'd7, 32'd42, 1'b0);
        tick();
        mul("mul_zero", 32'h1234_5678, 32'd0, 32'd0, 1'b0);
        tick();

        // reset during a multiply abandons it
        issue(ALU_MUL, 32'd5, 32'd5);
        repeat (9) tick();
        chk("mid_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mrst_data", bus.data, 32'd0);
        chk("mrst_zero", {31'b0, bus.zero}, 32'd1);
        chk("mrst_done", {31'b0, bus.done}, 32'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        chk("mrst_no_done", done_cnt, 32'd0);
        chk("mrst_no_busy", busy_cnt, 32'd0);
        single("mrst_add", ALU_ADD, 32'd2, 32'd3, 32'd5);

        // back-to-back: ADD accepted on the edge right after done
        mul("b2b_mul", 32'd3, 32'd3, 32'd9, 1'b0);
        chk("b2b_mul_done", {31'b0, bus.done}, 32'd1);
        single("b2b_add", ALU_ADD, 32'd1, 32'd1, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
